// File: rtl/dsc_pkg.sv
// rtl/dsc_pkg.sv - shared constants, state encoding and rounding helper for the stochastic multiplier sequencer
package dsc_pkg;

  localparam int SNG_WIDTH  = 10;
  localparam int NUM_INPUTS = 3;
  localparam int RW         = NUM_INPUTS * SNG_WIDTH;
  localparam int OUT_WIDTH  = 10;
  localparam int SH         = RW - OUT_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    CAP   = 3'd4,
    OUT   = 3'd5
  } state_t;

  // Half of one output LSB for a right shift of sh bits; zero when nothing is shifted out.
  function automatic longint round_add(input int sh);
    if (sh > 0) begin
      return longint'(1) << (sh - 1);
    end
    return 0;
  endfunction

  localparam longint ROUND_ADD = round_add(SH);

endpackage

// File: rtl/dsc_norm.sv
// rtl/dsc_norm.sv - combinational round, shift and saturate of the raw product count
module dsc_norm
  import dsc_pkg::*;
#(
  parameter int RW        = dsc_pkg::RW,
  parameter int OUT_WIDTH = dsc_pkg::OUT_WIDTH,
  parameter int ROUND     = 1
) (
  input  logic [RW-1:0]        raw,
  output logic [OUT_WIDTH-1:0] z
);

  localparam int SHL = RW - OUT_WIDTH;

  generate
    if (SHL == 0) begin : g_pass
      assign z = raw;
    end else begin : g_shift
      localparam logic [RW:0] ADD = (ROUND != 0) ? (RW + 1)'(round_add(SHL)) : '0;
      logic [RW:0] sum;

      // Add the rounding constant one bit wider than raw so a carry-out can be seen and saturated.
      always_comb begin
        sum = {1'b0, raw} + ADD;
        if (sum[RW]) begin
          z = '1;
        end else begin
          z = sum[RW-1:SHL];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/dsc_mul_seq.sv
// rtl/dsc_mul_seq.sv - transaction sequencer around the serial deterministic stochastic multiplier
module dsc_mul_seq
  import dsc_pkg::*;
#(
  parameter int SNG_WIDTH  = dsc_pkg::SNG_WIDTH,
  parameter int NUM_INPUTS = dsc_pkg::NUM_INPUTS,
  parameter int OUT_WIDTH  = dsc_pkg::OUT_WIDTH,
  parameter int ROUND      = 1,
  parameter int MIN_RUN    = 1,
  parameter int MAX_CYCLES = 2 ** (NUM_INPUTS * SNG_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SNG_WIDTH-1:0]             a_in,
  input  logic [SNG_WIDTH-1:0]             b_in,
  input  logic [SNG_WIDTH-1:0]             c_in,
  output logic [SNG_WIDTH-1:0]             mul_a,
  output logic [SNG_WIDTH-1:0]             mul_b,
  output logic [SNG_WIDTH-1:0]             mul_c,
  output logic                             mul_rst,
  output logic                             mul_en,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0]  mul_z,
  input  logic                             mul_ov,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_WIDTH-1:0]             out_z,
  output logic [NUM_INPUTS*SNG_WIDTH-1:0]  out_raw,
  output logic                             out_limit,
  output logic                             busy
);

  localparam int RWL = NUM_INPUTS * SNG_WIDTH;
  // One spare bit so the count can reach MAX_CYCLES without wrapping.
  localparam int CW  = $clog2(MAX_CYCLES) + 1;

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        cyc_cnt;
  logic                 ov_hit;
  logic                 lim_hit;
  logic                 run_done;
  logic [OUT_WIDTH-1:0] norm_z;

  // mul_ov is only trusted once the multiplier has had MIN_RUN cycles to settle.
  assign ov_hit   = mul_ov && (cyc_cnt >= CW'(MIN_RUN));
  assign lim_hit  = (cyc_cnt == CW'(MAX_CYCLES - 1));
  assign run_done = ov_hit || lim_hit;

  dsc_norm #(
    .RW        (RWL),
    .OUT_WIDTH (OUT_WIDTH),
    .ROUND     (ROUND)
  ) u_norm (
    .raw (mul_z),
    .z   (norm_z)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one transaction walks IDLE -> CLR -> RUN -> DRAIN -> CAP -> OUT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CLR;
      CLR:     state_d = RUN;
      RUN:     if (run_done) state_d = DRAIN;
      DRAIN:   state_d = CAP;
      CAP:     state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    mul_rst   = (state_q == CLR);
    mul_en    = (state_q == RUN);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  // Operand latch, cycle counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a     <= '0;
      mul_b     <= '0;
      mul_c     <= '0;
      cyc_cnt   <= '0;
      out_raw   <= '0;
      out_z     <= '0;
      out_limit <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mul_a <= a_in;
            mul_b <= b_in;
            mul_c <= c_in;
          end
        end
        CLR: begin
          cyc_cnt <= '0;
        end
        RUN: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          if (run_done) begin
            out_limit <= lim_hit && !ov_hit;
          end
        end
        CAP: begin
          out_raw <= mul_z;
          out_z   <= norm_z;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// tb/tb_dsc_mul_seq.sv - randomized self-checking bench for dsc_mul_seq with behavioural multiplier stubs
module tb_dsc_mul_seq;

  localparam int SW   = 4;
  localparam int NI   = 3;
  localparam int RWT  = 12;
  localparam int OW   = 4;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [SW-1:0] a_in, b_in, c_in;
  logic          no_ov;

  logic          in_ready0, mul_rst0, mul_en0, out_valid0, out_limit0, busy0, mul_ov0;
  logic [SW-1:0] mul_a0, mul_b0, mul_c0;
  logic [RWT-1:0] mul_z0, out_raw0;
  logic [OW-1:0] out_z0;

  logic          in_ready1, mul_rst1, mul_en1, out_valid1, out_limit1, busy1, mul_ov1;
  logic [SW-1:0] mul_a1, mul_b1, mul_c1;
  logic [RWT-1:0] mul_z1, out_raw1;
  logic [OW-1:0] out_z1;

  dsc_mul_seq #(
    .SNG_WIDTH(SW), .NUM_INPUTS(NI), .OUT_WIDTH(OW), .ROUND(1), .MIN_RUN(1), .MAX_CYCLES(MAXC)
  ) dut_rnd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_c(mul_c0),
    .mul_rst(mul_rst0), .mul_en(mul_en0), .mul_z(mul_z0), .mul_ov(mul_ov0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_z(out_z0), .out_raw(out_raw0),
    .out_limit(out_limit0), .busy(busy0)
  );

  dsc_mul_seq #(
    .SNG_WIDTH(SW), .NUM_INPUTS(NI), .OUT_WIDTH(OW), .ROUND(0), .MIN_RUN(1), .MAX_CYCLES(MAXC)
  ) dut_trn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_c(mul_c1),
    .mul_rst(mul_rst1), .mul_en(mul_en1), .mul_z(mul_z1), .mul_ov(mul_ov1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_z(out_z1), .out_raw(out_raw1),
    .out_limit(out_limit1), .busy(busy1)
  );

  // Behavioural multipliers: count up to a*b*c while enabled, flag done once the count is reached.
  logic [RWT-1:0] cnt0 = '0;
  logic [RWT-1:0] cnt1 = '0;
  logic [RWT-1:0] prod0, prod1;
  assign prod0   = RWT'(mul_a0) * RWT'(mul_b0) * RWT'(mul_c0);
  assign prod1   = RWT'(mul_a1) * RWT'(mul_b1) * RWT'(mul_c1);
  assign mul_z0  = cnt0;
  assign mul_z1  = cnt1;
  assign mul_ov0 = !no_ov && (cnt0 >= prod0);
  assign mul_ov1 = !no_ov && (cnt1 >= prod1);

  always @(posedge clk) begin
    if (mul_rst0) cnt0 <= '0;
    else if (mul_en0 && cnt0 < prod0) cnt0 <= cnt0 + 1'b1;
    if (mul_rst1) cnt1 <= '0;
    else if (mul_en1 && cnt1 < prod1) cnt1 <= cnt1 + 1'b1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model_round(input int raw);
    int s;
    s = raw + 128;
    if (s > 4095) return 15;
    return s / 256;
  endfunction

  function automatic int model_trunc(input int raw);
    return raw / 256;
  endfunction

  // Run length is the product (at least MIN_RUN+1 cycles) or the hard limit; plus CLR, DRAIN, CAP.
  function automatic int model_latency(input int p, input bit nov);
    if (nov) return MAXC + 3;
    return ((p < 1) ? 1 : p) + 4;
  endfunction

  task automatic reset_check(input string tag);
    check({tag, "_in_ready"}, in_ready0, 1);
    check({tag, "_out_valid"}, {out_valid0, out_valid1}, 0);
    check({tag, "_mul_en_rst"}, {mul_en0, mul_rst0}, 0);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_out_z"}, out_z0, 0);
    check({tag, "_out_raw"}, out_raw0, 0);
    check({tag, "_out_limit"}, out_limit0, 0);
    check({tag, "_mul_abc"}, {mul_a0, mul_b0, mul_c0}, 0);
  endtask

  // One full transaction; starts and ends just after a falling edge.
  task automatic run_txn(input int a, input int b, input int c, input bit nov, input bit stall);
    int p, n;
    bit bad;
    logic [OW-1:0] z_hold;
    logic [RWT-1:0] raw_hold;
    p = a * b * c;
    no_ov = nov;
    out_ready = !stall;
    a_in = SW'(a); b_in = SW'(b); c_in = SW'(c);
    in_valid = 1'b1;
    check("idle_in_ready", in_ready0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    a_in = SW'($urandom); b_in = SW'($urandom); c_in = SW'($urandom);
    n = 0;
    bad = 1'b0;
    while (!out_valid0 && n < 6000) begin
      if (in_ready0 || !busy0) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check("latency", n, model_latency(p, nov));
    check("busy_not_ready", bad, 0);
    check("lockstep_valid", out_valid1, 1);
    check("out_raw", out_raw0, p);
    check("out_z_round", out_z0, model_round(p));
    check("out_z_trunc", out_z1, model_trunc(p));
    check("out_limit", out_limit0, nov);
    if (stall) begin
      z_hold = out_z0;
      raw_hold = out_raw0;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'b1;
        a_in = SW'($urandom); b_in = SW'($urandom); c_in = SW'($urandom);
        @(negedge clk);
        if (!out_valid0 || out_z0 !== z_hold || out_raw0 !== raw_hold ||
            out_limit0 !== nov || in_ready0) bad = 1'b1;
      end
      check("stall_hold", bad, 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("released", out_valid0, 0);
    check("back_idle", in_ready0, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    no_ov = 1'b0;
    a_in = '0; b_in = '0; c_in = '0;
    @(negedge clk);
    @(negedge clk);
    reset_check("reset");
    rst = 1'b0;
    @(negedge clk);

    run_txn(8, 8, 8, 1'b0, 1'b0);
    run_txn(15, 15, 15, 1'b0, 1'b0);
    run_txn(0, 5, 7, 1'b0, 1'b0);
    run_txn(15, 15, 15, 1'b1, 1'b0);
    run_txn(3, 4, 5, 1'b0, 1'b1);

    for (int t = 0; t < 30; t++) begin
      run_txn($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end

    // Reset while the multiplier is running.
    no_ov = 1'b0;
    out_ready = 1'b1;
    a_in = 4'd8; b_in = 4'd8; c_in = 4'd8;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_run_busy", mul_en0, 1);
    rst = 1'b1;
    @(negedge clk);
    reset_check("rst_run");
    rst = 1'b0;
    @(negedge clk);
    run_txn(2, 3, 4, 1'b0, 1'b0);

    // Reset while the result is waiting for the consumer.
    out_ready = 1'b0;
    a_in = 4'd1; b_in = 4'd1; c_in = 4'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_out_valid", out_valid0, 1);
    rst = 1'b1;
    @(negedge clk);
    reset_check("rst_out");
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    run_txn(7, 7, 7, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
